// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int PC_W      = 64;
    localparam int REG_W     = 5;
    localparam int CNT_W_DEF = 32;

    typedef enum logic {
        PC_RUN   = 1'b0,
        PC_RWAIT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage controls and counters out.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic              ex_redirect;
    logic [PC_W-1:0]   ex_redirect_pc;
    logic              ex_is_load;
    logic [REG_W-1:0]  ex_rd;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              ifu_busy;
    logic              lsu_busy;

    logic              if_stall;
    logic              if_nop;
    logic              id_flush;
    logic              ex_stall;
    logic              pc_redirect;
    logic [PC_W-1:0]   pc_target;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Pipeline side.
    modport master (
        output ex_redirect, ex_redirect_pc, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, ifu_busy, lsu_busy,
        input  if_stall, if_nop, id_flush, ex_stall, pc_redirect, pc_target,
               stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  ex_redirect, ex_redirect_pc, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, ifu_busy, lsu_busy,
        output if_stall, if_nop, id_flush, ex_stall, pc_redirect, pc_target,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use comparator: flags an ID source that reads the destination of a load in EX.
// Purely combinational; x0 never creates a hazard.
module hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_is_load_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    output logic             load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    assign load_use_o = ex_is_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: LSU stall > EX redirect > load-use, zero-cycle controls.
// A redirect raised while IF has a fetch in flight is parked in tgt_q until IF goes idle.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input logic         clock,
    input logic         reset,
    pipe_ctrl_if.slave  io
);

    pc_state_e        state_q, state_d;
    logic [PC_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             load_use;
    logic             if_stall;
    logic             if_nop;
    logic             id_flush;
    logic             ex_stall;
    logic             pc_redirect;
    logic [PC_W-1:0]  pc_target;

    hazard_det u_hazard_det (
        .ex_is_load_i  (io.ex_is_load),
        .ex_rd_i       (io.ex_rd),
        .id_rs1_i      (io.id_rs1),
        .id_rs2_i      (io.id_rs2),
        .id_rs1_used_i (io.id_rs1_used),
        .id_rs2_used_i (io.id_rs2_used),
        .load_use_o    (load_use)
    );

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        if_stall    = 1'b0;
        if_nop      = 1'b0;
        id_flush    = 1'b0;
        ex_stall    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;

        if (!reset) begin
            state_d = PC_RUN;
        end else if (io.lsu_busy) begin
            // EX is frozen and will re-present any redirect once the LSU frees up.
            if_stall = 1'b1;
            ex_stall = 1'b1;
        end else begin
            unique case (state_q)
                PC_RUN: begin
                    if (io.ex_redirect) begin
                        if_nop   = 1'b1;
                        id_flush = 1'b1;
                        if (io.ifu_busy) begin
                            tgt_d   = io.ex_redirect_pc;
                            state_d = PC_RWAIT;
                        end else begin
                            pc_redirect = 1'b1;
                            pc_target   = io.ex_redirect_pc;
                        end
                    end else if (load_use) begin
                        if_stall = 1'b1;
                        id_flush = 1'b1;
                    end
                end
                PC_RWAIT: begin
                    if_nop = 1'b1;
                    if (io.ex_redirect) begin
                        tgt_d    = io.ex_redirect_pc;
                        id_flush = 1'b1;
                    end
                    // Latest redirect wins, even when it lands in the release cycle.
                    if (!io.ifu_busy) begin
                        pc_redirect = 1'b1;
                        pc_target   = tgt_d;
                        state_d     = PC_RUN;
                    end
                end
                default: state_d = PC_RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q + CNT_W'(if_stall | ex_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(id_flush);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= PC_RUN;
            tgt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign io.if_stall    = if_stall;
    assign io.if_nop      = if_nop;
    assign io.id_flush    = id_flush;
    assign io.ex_stall    = ex_stall;
    assign io.pc_redirect = pc_redirect;
    assign io.pc_target   = pc_target;
    assign io.stall_cnt   = stall_cnt_q;
    assign io.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios followed by random traffic.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus.slave)
    );

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [63:0] rpc;
        logic        ld;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        ifu;
        logic        lsu;
    } stim_t;

    typedef struct {
        logic          if_stall;
        logic          if_nop;
        logic          id_flush;
        logic          ex_stall;
        logic          pc_redirect;
        logic [63:0]   pc_target;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: one pending-redirect slot plus two plain integer counters.
    bit          pend   = 0;
    logic [63:0] ptgt   = '0;
    int          m_scnt = 0;
    int          m_fcnt = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1'b1, redir: 1'b0, rpc: 64'd0, ld: 1'b0, rd: 5'd0, rs1: 5'd0,
              rs2: 5'd0, u1: 1'b0, u2: 1'b0, ifu: 1'b0, lsu: 1'b0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t        e;
        bit          lu;
        bit          n_pend;
        logic [63:0] n_tgt;
        reset              = s.rst_n;
        bus.ex_redirect    = s.redir;
        bus.ex_redirect_pc = s.rpc;
        bus.ex_is_load     = s.ld;
        bus.ex_rd          = s.rd;
        bus.id_rs1         = s.rs1;
        bus.id_rs2         = s.rs2;
        bus.id_rs1_used    = s.u1;
        bus.id_rs2_used    = s.u2;
        bus.ifu_busy       = s.ifu;
        bus.lsu_busy       = s.lsu;

        e = '{if_stall: 1'b0, if_nop: 1'b0, id_flush: 1'b0, ex_stall: 1'b0,
              pc_redirect: 1'b0, pc_target: 64'd0, scnt: CW'(m_scnt), fcnt: CW'(m_fcnt)};
        n_pend = pend;
        n_tgt  = ptgt;
        lu = s.ld && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));

        if (!s.rst_n) begin
            n_pend = 0;
            n_tgt  = '0;
        end else if (s.lsu) begin
            e.if_stall = 1'b1;
            e.ex_stall = 1'b1;
        end else if (pend) begin
            e.if_nop = 1'b1;
            if (s.redir) begin
                n_tgt      = s.rpc;
                e.id_flush = 1'b1;
            end
            if (!s.ifu) begin
                e.pc_redirect = 1'b1;
                e.pc_target   = n_tgt;
                n_pend        = 0;
            end
        end else if (s.redir) begin
            e.if_nop   = 1'b1;
            e.id_flush = 1'b1;
            if (s.ifu) begin
                n_pend = 1;
                n_tgt  = s.rpc;
            end else begin
                e.pc_redirect = 1'b1;
                e.pc_target   = s.rpc;
            end
        end else if (lu) begin
            e.if_stall = 1'b1;
            e.id_flush = 1'b1;
        end
        sb.push_back(e);

        @(posedge clock);
        #1;
        pend = n_pend;
        ptgt = n_tgt;
        if (!s.rst_n) begin
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            m_scnt = (m_scnt + int'(e.if_stall | e.ex_stall)) % (1 << CW);
            m_fcnt = (m_fcnt + int'(e.id_flush)) % (1 << CW);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.if_stall !== e.if_stall || bus.if_nop !== e.if_nop ||
                    bus.id_flush !== e.id_flush || bus.ex_stall !== e.ex_stall ||
                    bus.pc_redirect !== e.pc_redirect || bus.pc_target !== e.pc_target ||
                    bus.stall_cnt !== e.scnt || bus.flush_cnt !== e.fcnt ||
                    (bus.if_stall && bus.if_nop)) begin
                    miscompares++;
                    $display("FAIL ctrl vec %0d @%0t: got st=%b nop=%b fl=%b exs=%b red=%b tgt=%h sc=%0d fc=%0d, want st=%b nop=%b fl=%b exs=%b red=%b tgt=%h sc=%0d fc=%0d",
                             vectors, $time, bus.if_stall, bus.if_nop, bus.id_flush,
                             bus.ex_stall, bus.pc_redirect, bus.pc_target, bus.stall_cnt,
                             bus.flush_cnt, e.if_stall, e.if_nop, e.id_flush, e.ex_stall,
                             e.pc_redirect, e.pc_target, e.scnt, e.fcnt);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        reset = 1'b0;
        apply_defaults();
        @(posedge clock);
        #1;

        s = idle(); s.rst_n = 1'b0;
        apply(s);
        apply(s);
        apply(idle());

        // Load-use on rs2, then the same pattern against x0.
        s = idle(); s.ld = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
        apply(s);
        apply(idle());
        s.rd = 5'd0; s.rs2 = 5'd0;
        apply(s);

        // Redirect with idle IFU.
        s = idle(); s.redir = 1'b1; s.rpc = 64'h8000_0100;
        apply(s);
        apply(idle());

        // Deferred redirect: three busy cycles, strobe on the fourth.
        s = idle(); s.redir = 1'b1; s.rpc = 64'h8000_0200; s.ifu = 1'b1;
        apply(s);
        s = idle(); s.ifu = 1'b1;
        apply(s);
        apply(s);
        apply(idle());
        apply(idle());

        // LSU back-pressure masks redirect and load-use.
        s = idle(); s.lsu = 1'b1; s.redir = 1'b1; s.rpc = 64'h8000_0300;
        s.ld = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1;
        apply(s);
        apply(s);
        s.lsu = 1'b0; s.ld = 1'b0;
        apply(s);
        apply(idle());

        // Reset while a redirect is parked.
        s = idle(); s.redir = 1'b1; s.rpc = 64'h8000_0400; s.ifu = 1'b1;
        apply(s);
        s = idle(); s.rst_n = 1'b0; s.ifu = 1'b1;
        apply(s);
        for (int i = 0; i < 4; i++) apply(idle());

        // Counter wrap at CNT_W=4: 17 stall cycles from reset.
        s = idle(); s.rst_n = 1'b0;
        apply(s);
        s = idle(); s.lsu = 1'b1;
        for (int i = 0; i < 17; i++) apply(s);
        #1;
        vectors++;
        if (bus.stall_cnt !== CW'(1)) begin
            miscompares++;
            $display("FAIL wrap: stall_cnt=%0d want 1", bus.stall_cnt);
        end
        apply(idle());

        // Random traffic with small register indices to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 59) != 0);
            s.redir = ($urandom_range(0, 3) == 0);
            s.rpc   = {32'h8000_0000, 32'($urandom) & 32'hffff_fffc};
            s.ld    = 1'($urandom);
            s.rd    = 5'($urandom_range(0, 3));
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.u1    = 1'($urandom);
            s.u2    = 1'($urandom);
            s.ifu   = ($urandom_range(0, 2) != 0);
            s.lsu   = ($urandom_range(0, 3) == 0);
            apply(s);
        end

        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic apply_defaults();
        bus.ex_redirect    = 1'b0;
        bus.ex_redirect_pc = '0;
        bus.ex_is_load     = 1'b0;
        bus.ex_rd          = '0;
        bus.id_rs1         = '0;
        bus.id_rs2         = '0;
        bus.id_rs1_used    = 1'b0;
        bus.id_rs2_used    = 1'b0;
        bus.ifu_busy       = 1'b0;
        bus.lsu_busy       = 1'b0;
    endtask

endmodule
